// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receiver.
// Contents: rx_state_e receiver FSM states, register byte offsets (addr[3:0]),
// and STATUS register bit positions.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [3:0] RxDataOff = 4'h0;
    localparam logic [3:0] StatusOff = 4'h4;
    localparam logic [3:0] CtrlOff   = 4'h8;
    localparam logic [3:0] LevelOff  = 4'hC;

    localparam int StNotEmpty  = 0;
    localparam int StFull      = 1;
    localparam int StOverflow  = 2;
    localparam int StFrameErr  = 3;
    localparam int StParityErr = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding received bytes.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   push_i, data_i   write request and data; accepted when not full or when popping
//   pop_i, data_o    read request and head-of-queue data (combinational)
//   full_o, empty_o  occupancy flags
//   level_o          occupancy 0..Depth
module uart_rx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     level_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int LvlW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = level_q == LvlW'(Depth);
    assign empty_o = level_q == '0;
    assign level_o = level_q;
    assign data_o  = mem_q[rptr_q];

    // A full FIFO still accepts a push when the head leaves on the same edge;
    // the write then lands in the slot being vacated.
    always_comb begin
        do_push = push_i & (~full_o | pop_i);
        do_pop  = pop_i & ~empty_o;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q + LvlW'(do_push) - LvlW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 8N1 UART receiver with byte FIFO and level interrupt.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   device_req_i/addr_i/we_i/be_i/wdata_i   device bus request (addr[3:0] decoded)
//   device_rvalid_o/rdata_o   registered response, one cycle after req
//   uart_rx_i                 asynchronous serial line, idle high
//   rx_irq_o                  irq_en & (not_empty | OVERFLOW | FRAME_ERR | PARITY_ERR)
// Build option: define UART_RX_PARITY_EN for 8E1 frames with an even parity bit.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int FifoDepth      = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    input  logic        uart_rx_i,
    output logic        rx_irq_o
);

    localparam int ClocksPerBit = ClockFrequency / BaudRate;
    localparam int CntW = $clog2(ClocksPerBit);
    localparam int LvlW = $clog2(FifoDepth) + 1;
    localparam logic [CntW-1:0] HalfBit = CntW'(ClocksPerBit / 2);
    localparam logic [CntW-1:0] LastBit = CntW'(ClocksPerBit - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AfterData = PARITY;
`else
    localparam rx_state_e AfterData = STOP;
`endif

    rx_state_e        state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             bad_q, bad_d;
    logic             irq_en_q, irq_en_d, ovf_q, ovf_d, ferr_q, ferr_d, perr_q, perr_d;
    logic             rvalid_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             rx_s, push, ferr_set, perr_set, ovf_set;
    logic             rd_en, wr_en, pop, full, empty;
    logic [3:0]       addr;
    logic [2:0]       clr;
    logic [7:0]       head;
    logic [LvlW-1:0]  level;
    logic [31:0]      status;
    logic             unused_bits;

    assign unused_bits = ^{device_addr_i[31:4], device_be_i[3:1], device_wdata_i};

    uart_rx_fifo #(.Width(8), .Depth(FifoDepth)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (shift_q),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign sync_d = {sync_q[0], uart_rx_i};
    assign rx_s   = sync_q[1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        bad_d    = bad_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bad_d = 1'b0;
                state_d = rx_s ? IDLE : START;
            end
            START: if (cnt_q == HalfBit) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == LastBit) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                state_d = (bit_q == 3'd7) ? AfterData : DATA;
            end
            PARITY: if (cnt_q == LastBit) begin
                cnt_d    = '0;
                perr_set = ^{shift_q, rx_s};
                bad_d    = perr_set;
                state_d  = STOP;
            end
            STOP: if (cnt_q == LastBit) begin
                cnt_d    = '0;
                push     = rx_s & ~bad_q;
                ferr_set = ~rx_s;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign addr    = device_addr_i[3:0];
    assign rd_en   = device_req_i & ~device_we_i;
    assign wr_en   = device_req_i & device_we_i & device_be_i[0];
    assign pop     = rd_en & (addr == RxDataOff) & ~empty;
    assign ovf_set = push & full & ~pop;
    assign clr     = (wr_en && addr == StatusOff) ? device_wdata_i[StParityErr:StOverflow] : 3'b0;

    // A flag being set in the same cycle as its write-1-to-clear stays set.
    always_comb begin
        irq_en_d = (wr_en && addr == CtrlOff) ? device_wdata_i[0] : irq_en_q;
        ovf_d    = ovf_set | (ovf_q & ~clr[0]);
        ferr_d   = ferr_set | (ferr_q & ~clr[1]);
        perr_d   = perr_set | (perr_q & ~clr[2]);
        status              = '0;
        status[StNotEmpty]  = ~empty;
        status[StFull]      = full;
        status[StOverflow]  = ovf_q;
        status[StFrameErr]  = ferr_q;
        status[StParityErr] = perr_q;
        rdata_d = !rd_en               ? 32'h0 :
                  (addr == RxDataOff)  ? {24'h0, empty ? 8'h0 : head} :
                  (addr == StatusOff)  ? status :
                  (addr == CtrlOff)    ? {31'h0, irq_en_q} :
                  (addr == LevelOff)   ? 32'(level) : 32'h0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            bad_q    <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            bad_q    <= bad_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            rvalid_q <= device_req_i;
            rdata_q  <= rdata_d;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign rx_irq_o        = irq_en_q & (~empty | ovf_q | ferr_q | perr_q);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (43 clocks per bit).
module tb_uart_rx;

    localparam int Cpb  = 5_000_000 / 115_200;
    localparam int Half = Cpb / 2;
`ifdef UART_RX_PARITY_EN
    localparam int BitsAfterStart = 10;
`else
    localparam int BitsAfterStart = 9;
`endif
    // Posedge (counted from the start-bit drive) on which the stop bit is sampled:
    // 2 sync flops + start detect, half-bit check, then one bit time per later bit.
    localparam int PushEdge = 4 + Half + Cpb * BitsAfterStart;

    logic        clk, rst_n, req, we, line, rvalid, irq;
    logic [31:0] addr, wdata, rdata, d;
    logic [3:0]  be;
    int          total, passed;
`ifdef UART_RX_PARITY_EN
    logic        par_flip;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];

    uart_rx #(.ClockFrequency(5_000_000), .BaudRate(115_200), .FifoDepth(8)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .device_req_i    (req),
        .device_addr_i   (addr),
        .device_we_i     (we),
        .device_be_i     (be),
        .device_wdata_i  (wdata),
        .device_rvalid_o (rvalid),
        .device_rdata_o  (rdata),
        .uart_rx_i       (line),
        .rx_irq_o        (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] data);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
        @(negedge clk);
        req = 1'b0;
        check("rvalid", {31'h0, rvalid}, 32'h1);
        data = rdata;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(name, v, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] v);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = a; be = b; wdata = v;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    // Must be entered on a negedge; leaves the line idle for one bit time.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        line = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            repeat (Cpb) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        line = ^b ^ par_flip;
        repeat (Cpb) @(negedge clk);
`endif
        line = stop;
        repeat (Cpb) @(negedge clk);
        line = 1'b1;
        repeat (Cpb) @(negedge clk);
    endtask

    initial begin
        total = 0; passed = 0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; line = 1'b1;
        addr = '0; wdata = '0; be = '0;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
`endif
        vecs[0]  = '{1'b0, 32'h0, 4'hF, 32'h0, 32'h0, "rxdata_empty"};
        vecs[1]  = '{1'b0, 32'h4, 4'hF, 32'h0, 32'h0, "status_rst"};
        vecs[2]  = '{1'b0, 32'h8, 4'hF, 32'h0, 32'h0, "ctrl_rst"};
        vecs[3]  = '{1'b0, 32'hC, 4'hF, 32'h0, 32'h0, "level_rst"};
        vecs[4]  = '{1'b1, 32'h8, 4'hF, 32'h1, 32'h0, "wr_ctrl"};
        vecs[5]  = '{1'b0, 32'h8, 4'hF, 32'h0, 32'h1, "ctrl_set"};
        vecs[6]  = '{1'b1, 32'h8, 4'hE, 32'h0, 32'h0, "wr_ctrl_nobe0"};
        vecs[7]  = '{1'b0, 32'h8, 4'hF, 32'h0, 32'h1, "ctrl_be0_needed"};
        vecs[8]  = '{1'b1, 32'hC, 4'hF, 32'hFFFF_FFFF, 32'h0, "wr_level"};
        vecs[9]  = '{1'b0, 32'hC, 4'hF, 32'h0, 32'h0, "level_ro"};
        vecs[10] = '{1'b0, 32'h2, 4'hF, 32'h0, 32'h0, "unmapped"};
        vecs[11] = '{1'b1, 32'h8, 4'hF, 32'h0, 32'h0, "wr_ctrl0"};
        vecs[12] = '{1'b0, 32'h8, 4'hF, 32'h0, 32'h0, "ctrl_clr"};
        vecs[13] = '{1'b0, 32'h4, 4'hF, 32'h0, 32'h0, "status_idle"};

        repeat (3) @(negedge clk);
        check("rst_rvalid", {31'h0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].be, vecs[i].wdata);
            else read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end

        send_frame(8'hA5, 1'b1);
        read_check("a5_status", 32'h4, 32'h1);
        read_check("a5_level", 32'hC, 32'h1);
        read_check("a5_data", 32'h0, 32'hA5);
        read_check("a5_status_after", 32'h4, 32'h0);

        line = 1'b0;
        repeat (10) @(negedge clk);
        line = 1'b1;
        repeat (2 * Cpb) @(negedge clk);
        read_check("glitch_status", 32'h4, 32'h0);
        read_check("glitch_level", 32'hC, 32'h0);
        send_frame(8'h5A, 1'b1);
        read_check("post_glitch_data", 32'h0, 32'h5A);

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        read_check("ovf_level", 32'hC, 32'h8);
        read_check("ovf_status", 32'h4, 32'h7);
        check("ovf_irq_masked", {31'h0, irq}, 32'h0);
        for (int i = 1; i <= 8; i++) read_check("ovf_data", 32'h0, 32'(i));
        read_check("ovf_status_drained", 32'h4, 32'h4);
        bus_write(32'h4, 4'hF, 32'h4);
        read_check("ovf_cleared", 32'h4, 32'h0);

        bus_write(32'h8, 4'hF, 32'h1);
        send_frame(8'h3C, 1'b0);
        read_check("ferr_status", 32'h4, 32'h8);
        read_check("ferr_level", 32'hC, 32'h0);
        check("ferr_irq", {31'h0, irq}, 32'h1);
        bus_write(32'h4, 4'hF, 32'h8);
        check("ferr_irq_clr", {31'h0, irq}, 32'h0);
        read_check("ferr_cleared", 32'h4, 32'h0);
        bus_write(32'h8, 4'hF, 32'h0);

        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1);
        read_check("full_level", 32'hC, 32'h8);
        @(negedge clk);
        fork
            send_frame(8'h18, 1'b1);
            begin
                repeat (PushEdge - 1) @(posedge clk);
                @(negedge clk);
                req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'hF;
                @(negedge clk);
                req = 1'b0;
                check("coll_rvalid", {31'h0, rvalid}, 32'h1);
                check("coll_head", rdata, 32'h10);
            end
        join
        read_check("coll_level", 32'hC, 32'h8);
        read_check("coll_status", 32'h4, 32'h3);
        for (int i = 1; i <= 8; i++) read_check("coll_order", 32'h0, 32'h10 + 32'(i));
        read_check("coll_empty", 32'h4, 32'h0);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        read_check("perr_status", 32'h4, 32'h10);
        read_check("perr_level", 32'hC, 32'h0);
        bus_write(32'h4, 4'hF, 32'h10);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        read_check("par_ok_status", 32'h4, 32'h1);
        read_check("par_ok_data", 32'h0, 32'h07);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
